// File: rtl/periferico_fifo_if.sv
// Handshake and read-port bundle for periferico_fifo.
// The master modport is the sender/reader side; the slave modport is the buffer.
interface periferico_fifo_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]       dado;
  logic [1:0]              send;
  logic [1:0]              ack;
  logic                    rd_en;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    overflow;
  logic                    clr_ovf;

  modport master (
    output dado, send, rd_en, clr_ovf,
    input  ack, rd_data, rd_valid, count, full, overflow
  );

  modport slave (
    input  dado, send, rd_en, clr_ovf,
    output ack, rd_data, rd_valid, count, full, overflow
  );
endinterface

// File: rtl/periferico_fifo.sv
// Receive buffer behind a send/ack handshake: one word is stored per request,
// a request while full is refused and latched in a sticky overflow flag.
module periferico_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  periferico_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACK, NACK} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic                req, full_w, empty, push, pop, refuse;

  assign req    = |bus.send;
  assign full_w = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign pop    = bus.rd_en && !empty;

  // Push/refuse decisions are taken only in IDLE, so a held request counts once.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    refuse  = 1'b0;
    bus.ack = 2'b00;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (full_w) begin
            refuse  = 1'b1;
            state_d = NACK;
          end else begin
            push    = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        bus.ack = 2'b01;
        if (!req) state_d = IDLE;
      end
      NACK: begin
        bus.ack = 2'b10;
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      // A refusal on the same edge as clr_ovf leaves the flag set.
      if (refuse)           ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  // Storage carries no reset; stale entries are hidden by count/rd_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.dado;
  end

  assign bus.rd_data  = mem[rd_ptr];
  assign bus.rd_valid = !empty;
  assign bus.count    = cnt;
  assign bus.full     = full_w;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_periferico_fifo.sv
// Directed bench for periferico_fifo: a queue scoreboard holds the words the
// buffer should contain, checked against the read port as they are popped.
module tb_periferico_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [DATA_W-1:0] sb[$];
  logic              ovf_m;

  periferico_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  periferico_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"},    32'(bus.count), 32'(sb.size()));
    check({tag, ".full"},     32'(bus.full), 32'(sb.size() == DEPTH));
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(sb.size() != 0));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf_m));
  endtask

  // One full handshake: request held for 'hold' sampling edges, then released.
  task automatic handshake(input string tag, input logic [DATA_W-1:0] d,
                           input logic [1:0] sv, input int hold);
    logic was_full;
    was_full = (sb.size() == DEPTH);
    bus.dado = d;
    bus.send = sv;
    step();
    if (was_full) ovf_m = 1'b1;
    else          sb.push_back(d);
    for (int i = 0; i < hold; i++) begin
      check({tag, ".ack"}, 32'(bus.ack), was_full ? 32'h2 : 32'h1);
      if (i < hold - 1) step();
    end
    bus.send = 2'b00;
    step();
    check({tag, ".ack_idle"}, 32'(bus.ack), 32'h0);
    check_status(tag);
  endtask

  task automatic pop_check(input string tag);
    logic [DATA_W-1:0] exp;
    exp = sb.pop_front();
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'h1);
    check({tag, ".rd_data"},  32'(bus.rd_data), 32'(exp));
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({tag, ".count"}, 32'(bus.count), 32'(sb.size()));
  endtask

  initial begin
    rst         = 1'b1;
    bus.dado    = '0;
    bus.send    = 2'b00;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    ovf_m       = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset.ack", 32'(bus.ack), 32'h0);
    check_status("reset");

    // Single transfer with request held for three cycles
    handshake("single", 16'hA5A5, 2'b01, 3);
    check("single.rd_data", 32'(bus.rd_data), 32'hA5A5);
    pop_check("single.pop");

    // Fill and refuse
    do_reset();
    for (int i = 1; i <= 4; i++) handshake("fill", DATA_W'(i), 2'b11, 1);
    handshake("refuse", 16'd5, 2'b10, 2);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check_status("drain_end");

    // Wrap-around
    for (int i = 10; i <= 15; i++) begin
      handshake("wrap", DATA_W'(i), 2'b01, 1);
      pop_check("wrap.pop");
    end
    check_status("wrap_end");

    // Simultaneous push and pop at count 2
    do_reset();
    handshake("sim", 16'd20, 2'b01, 1);
    handshake("sim", 16'd21, 2'b01, 1);
    bus.dado  = 16'd22;
    bus.send  = 2'b01;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    void'(sb.pop_front());
    sb.push_back(16'd22);
    check("sim.ack", 32'(bus.ack), 32'h1);
    check("sim.count", 32'(bus.count), 32'd2);
    check("sim.head", 32'(bus.rd_data), 32'd21);
    bus.send = 2'b00;
    step();
    handshake("sim", 16'd23, 2'b01, 1);
    handshake("sim", 16'd24, 2'b01, 1);
    // Request while full with a pop on the same edge is still refused
    bus.dado  = 16'd25;
    bus.send  = 2'b01;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    void'(sb.pop_front());
    ovf_m = 1'b1;
    check("fullpop.ack", 32'(bus.ack), 32'h2);
    check_status("fullpop");
    bus.send = 2'b00;
    step();

    // Reset while in ACK with three entries
    pop_check("pre_rst");
    bus.dado = 16'd32;
    bus.send = 2'b01;
    step();
    sb.push_back(16'd32);
    check("inack.ack", 32'(bus.ack), 32'h1);
    check("inack.count", 32'(bus.count), 32'd3);
    rst      = 1'b1;
    bus.send = 2'b00;
    step();
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    check("rst_ack.ack", 32'(bus.ack), 32'h0);
    check_status("rst_ack");
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check_status("underflow");

    // Reset mid-handshake with send still held becomes a new request
    bus.dado = 16'd40;
    bus.send = 2'b01;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_hold.ack", 32'(bus.ack), 32'h0);
    check("rst_hold.count", 32'(bus.count), 32'd0);
    bus.dado = 16'd41;
    step();
    sb.push_back(16'd41);
    check("rereq.ack", 32'(bus.ack), 32'h1);
    check_status("rereq");
    check("rereq.rd_data", 32'(bus.rd_data), 32'd41);
    bus.send = 2'b00;
    step();

    // clr_ovf on the same edge as a refusal: set wins
    handshake("ovf", 16'd42, 2'b01, 1);
    handshake("ovf", 16'd43, 2'b01, 1);
    handshake("ovf", 16'd44, 2'b01, 1);
    bus.dado    = 16'd45;
    bus.send    = 2'b01;
    bus.clr_ovf = 1'b1;
    step();
    ovf_m = 1'b1;
    check("clrset.ack", 32'(bus.ack), 32'h2);
    check_status("clrset");
    bus.send = 2'b00;
    step();
    bus.clr_ovf = 1'b0;
    ovf_m = 1'b0;
    check("clr.ack", 32'(bus.ack), 32'h0);
    check_status("clr");
    for (int i = 0; i < 4; i++) pop_check("ovf.drain");
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
